// File: rtl/ring_buff_reader.sv
// Drain stage for a ring buffer: issues read-enables, captures 1-cycle-latency read data into a
// 2-entry output queue and streams it out on valid/ready. Define RING_BUFF_READER_BURST_EN for burst mode.
module ring_buff_reader #(
  parameter int NUM_ENTRY  = 16,
  parameter int WIDTH_DATA = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         I_Empty,
  input  logic [$clog2(NUM_ENTRY):0]   I_Num,
  output logic                         O_Re,
  input  logic [WIDTH_DATA-1:0]        I_RData,
  output logic                         O_Valid,
  output logic [WIDTH_DATA-1:0]        O_Data,
  input  logic                         I_Ready,
  input  logic                         I_Flush,
  output logic                         O_Busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t                r_state, w_state_nxt;
  logic [WIDTH_DATA-1:0] r_mem [2];
  logic                  r_head, r_tail;
  logic [1:0]            r_occ;
  logic                  r_in_flight;
  logic                  w_push, w_pop;
  logic [2:0]            w_slots;

  // Free slots count the entry being popped this cycle, which sustains one read per cycle.
  assign w_pop   = O_Valid & I_Ready;
  assign w_push  = r_in_flight;
  assign w_slots = 3'd2 + {2'b00, w_pop} - {1'b0, r_occ} - {2'b00, r_in_flight};

  assign O_Valid = (r_occ != 2'd0);
  assign O_Data  = r_mem[r_head];
  assign O_Re    = (r_state == ST_RUN) & ~I_Empty & (w_slots != 3'd0) & ~I_Flush;
  assign O_Busy  = (r_state != ST_IDLE) | O_Valid | r_in_flight;

`ifdef RING_BUFF_READER_BURST_EN
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  localparam int NUM_W  = $clog2(NUM_ENTRY) + 1;

  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    if (I_Flush) begin
      w_state_nxt = ST_FLUSH;
      w_bcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_Num >= NUM_W'(BURST_LEN)) begin
            w_state_nxt = ST_RUN;
            w_bcnt_nxt  = BCNT_W'(BURST_LEN);
          end
        end
        ST_RUN: begin
          if (O_Re) begin
            w_bcnt_nxt = r_bcnt - BCNT_W'(1);
            if (r_bcnt == BCNT_W'(1)) w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_bcnt <= '0;
    else        r_bcnt <= w_bcnt_nxt;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^I_Num) ^ (BURST_LEN != 0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    if (I_Flush) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE: if (~I_Empty) w_state_nxt = ST_RUN;
        ST_RUN:  if (I_Empty & ~O_Re) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end
`endif

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_in_flight <= 1'b0;
      r_occ       <= 2'd0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      // NOTE: the queue storage is reset because O_Data (the head) must read 0 out of reset.
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_flight <= O_Re;
      if (I_Flush) begin
        // Flush wins over push and pop: queued data and the returning read are both dropped.
        r_occ  <= 2'd0;
        r_head <= 1'b0;
        r_tail <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= I_RData;
          r_tail        <= ~r_tail;
        end
        if (w_pop) r_head <= ~r_head;
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_buff_reader.sv
// Self-checking bench for ring_buff_reader: behavioural ring controller plus an output scoreboard.
// Build with RING_BUFF_READER_BURST_EN defined to exercise burst mode instead of the streaming tests.
module tb_ring_buff_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Empty;
  logic [4:0]  I_Num;
  logic        O_Re;
  logic [31:0] I_RData;
  logic        O_Valid;
  logic [31:0] O_Data;
  logic        I_Ready;
  logic        I_Flush;
  logic        O_Busy;

  ring_buff_reader #(.NUM_ENTRY(16), .WIDTH_DATA(32), .BURST_LEN(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .I_Empty (I_Empty),
    .I_Num   (I_Num),
    .O_Re    (O_Re),
    .I_RData (I_RData),
    .O_Valid (O_Valid),
    .O_Data  (O_Data),
    .I_Ready (I_Ready),
    .I_Flush (I_Flush),
    .O_Busy  (O_Busy)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ring  [$];
  logic [31:0] exp_q [$];
  logic [31:0] rdata_next;
  int          cyc, n_re, n_val, n_acc, first_re, first_val;
  int          re_run, max_re_run, val_run, max_val_run;
  logic        prev_valid, busy_at_fall;
  logic        s_re, s_valid, s_busy;
  logic [31:0] s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic clr_stats();
    n_re = 0; n_val = 0; n_acc = 0; first_re = -1; first_val = -1;
    re_run = 0; max_re_run = 0; val_run = 0; max_val_run = 0;
    prev_valid = 1'b0; busy_at_fall = 1'b1;
  endtask

  // One clock cycle, entered and left on a falling edge. Inputs come from the controller model,
  // outputs are sampled 1 time unit later, then the model and scoreboard advance.
  task automatic tick(input logic rdy, input logic flush);
    I_Empty = (ring.size() == 0);
    I_Num   = 5'(ring.size());
    I_RData = rdata_next;
    I_Ready = rdy;
    I_Flush = flush;
    #1;
    s_re = O_Re; s_valid = O_Valid; s_data = O_Data; s_busy = O_Busy;
    if (s_valid) begin
      n_val++; val_run++;
      if (first_val < 0) first_val = cyc;
      if (val_run > max_val_run) max_val_run = val_run;
    end else val_run = 0;
    if (prev_valid && !s_valid) busy_at_fall = s_busy;
    prev_valid = s_valid;
    if (s_valid && rdy && !flush) begin
      n_acc++;
      check("out_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("out_data", s_data, exp_q.pop_front());
    end
    if (flush) begin
      check("re_during_flush", s_re, 0);
      exp_q.delete();
    end
    rdata_next = 32'hDEAD_BEEF;
    if (s_re) begin
      n_re++; re_run++;
      if (first_re < 0) first_re = cyc;
      if (re_run > max_re_run) max_re_run = re_run;
      if (ring.size() != 0) begin
        rdata_next = ring.pop_front();
        exp_q.push_back(rdata_next);
      end else check("re_on_empty", s_re, 0);
    end else re_run = 0;
    @(negedge clock);
    cyc++;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(rdy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ring.delete(); exp_q.delete();
    rdata_next = 32'hDEAD_BEEF;
    I_Empty = 1'b1; I_Num = '0; I_RData = '0; I_Ready = 1'b0; I_Flush = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_re", O_Re, 0);
    check("rst_valid", O_Valid, 0);
    check("rst_data", O_Data, 0);
    check("rst_busy", O_Busy, 0);
    @(negedge clock);
    reset = 1'b1;
    cyc = 0;
  endtask

`ifndef RING_BUFF_READER_BURST_EN
  task automatic test_single();
    clr_stats();
    run(10, 1'b1);
    ring.push_back(32'hA5A5_0001);
    run(10, 1'b1);
    check("single_re_cycle", first_re, 11);
    check("single_re_count", n_re, 1);
    check("single_valid_cycle", first_val, 13);
    check("single_valid_count", n_val, 1);
    check("single_drained", exp_q.size(), 0);
  endtask
`else
  task automatic test_burst();
    clr_stats();
    for (int i = 0; i < 3; i++) ring.push_back(32'hB000_0000 + i);
    run(20, 1'b1);
    check("burst_hold_re", n_re, 0);
    for (int i = 3; i < 6; i++) ring.push_back(32'hB000_0000 + i);
    run(20, 1'b1);
    check("burst_re_count", n_re, 4);
    check("burst_acc_count", n_acc, 4);
    check("burst_left_in_ring", ring.size(), 2);
    check("burst_idle_busy", s_busy, 0);
  endtask
`endif

  initial begin
    do_reset();
`ifndef RING_BUFF_READER_BURST_EN
    test_single();

    // Back-pressure: only two reads may be outstanding while the consumer stalls.
    clr_stats();
    for (int i = 0; i < 4; i++) ring.push_back(32'hD000_0000 + i);
    run(10, 1'b0);
    check("bp_re_count", n_re, 2);
    check("bp_valid_held", s_valid, 1);
    check("bp_head_stable", s_data, 32'hD000_0000);
    run(12, 1'b1);
    check("bp_re_total", n_re, 4);
    check("bp_acc_total", n_acc, 4);
    check("bp_drained", exp_q.size(), 0);

    // Streaming at full rate.
    clr_stats();
    for (int i = 0; i < 8; i++) ring.push_back(32'h5000_0000 + 32'(i * 3));
    run(16, 1'b1);
    check("stream_re_count", n_re, 8);
    check("stream_re_run", max_re_run, 8);
    check("stream_valid_run", max_val_run, 8);
    check("stream_busy_fall", busy_at_fall, 0);
    check("stream_drained", exp_q.size(), 0);

    // Flush with one entry queued and one read returning; F0 and F1 must be lost.
    clr_stats();
    for (int i = 0; i < 4; i++) ring.push_back(32'hF000_0000 + i);
    run(3, 1'b0);
    tick(1'b0, 1'b1);
    check("flush_pre_valid", s_valid, 1);
    tick(1'b0, 1'b0);
    check("flush_valid_clr", s_valid, 0);
    check("flush_state_re", s_re, 0);
    check("flush_state_busy", s_busy, 1);
    clr_stats();
    run(12, 1'b1);
    check("flush_resume_re", n_re, 2);
    check("flush_resume_acc", n_acc, 2);
    check("flush_drained", exp_q.size(), 0);
`else
    test_burst();
`endif

    // Asynchronous reset between clock edges, mid-stream.
    for (int i = 0; i < 8; i++) ring.push_back(32'h7000_0000 + i);
    clr_stats();
    run(5, 1'b1);
`ifndef RING_BUFF_READER_BURST_EN
    check("mid_busy", s_busy, 1);
`endif
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", O_Valid, 0);
    check("arst_re", O_Re, 0);
    check("arst_busy", O_Busy, 0);
    do_reset();
`ifndef RING_BUFF_READER_BURST_EN
    test_single();
`else
    test_burst();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
